// File: rtl/regfile_pkg.sv
// Shared sizing and types for the CPU datapath register file.
package regfile_pkg;

  localparam int REG_W    = 32;
  localparam int REG_N    = 32;
  localparam int ZERO_REG = 0;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/regfile_3port.sv
// Three-port register file: two combinational read ports, one synchronous write port.
// Entry 0 reads as zero; optional same-cycle write-to-read forwarding.
module regfile_3port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = REG_W,
  parameter int DEPTH  = REG_N,
  parameter int BYPASS = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we3,
  input  logic [$clog2(DEPTH)-1:0]   ra1,
  input  logic [$clog2(DEPTH)-1:0]   ra2,
  input  logic [$clog2(DEPTH)-1:0]   wa3,
  input  logic [WIDTH-1:0]           wd3,
  output logic [WIDTH-1:0]           rd1,
  output logic [WIDTH-1:0]           rd2
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ZERO_A  = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  // Guards non-power-of-two depths: addresses past the last entry are dead.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != ZERO_A) && ({1'b0, a} < DEPTH_W);
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (we3 && addr_ok(wa3)) begin
      regs_d[wa3] = wd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd1 = '0;
    if (addr_ok(ra1)) begin
      rd1 = regs_q[ra1];
      if ((BYPASS != 0) && we3 && (wa3 == ra1)) begin
        rd1 = wd3;
      end
    end
  end

  always_comb begin
    rd2 = '0;
    if (addr_ok(ra2)) begin
      rd2 = regs_q[ra2];
      if ((BYPASS != 0) && we3 && (wa3 == ra2)) begin
        rd2 = wd3;
      end
    end
  end

endmodule

// File: tb/tb_regfile_3port.sv
// Scoreboard bench: one non-forwarding and one forwarding register file share stimulus.
module tb_regfile_3port;
  import regfile_pkg::*;

  logic      clk;
  logic      reset;
  logic      we3;
  reg_addr_t ra1, ra2, wa3;
  reg_data_t wd3;
  reg_data_t rd1_a, rd2_a, rd1_b, rd2_b;

  int total;
  int bad;

  typedef struct {
    string     name;
    reg_data_t e1a;
    reg_data_t e2a;
    reg_data_t e1b;
    reg_data_t e2b;
  } exp_t;

  exp_t exp_q[$];

  regfile_3port #(.WIDTH(32), .DEPTH(32), .BYPASS(0)) dut_a (
    .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2),
    .wa3(wa3), .wd3(wd3), .rd1(rd1_a), .rd2(rd2_a)
  );

  regfile_3port #(.WIDTH(32), .DEPTH(32), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .we3(we3), .ra1(ra1), .ra2(ra2),
    .wa3(wa3), .wd3(wd3), .rd1(rd1_b), .rd2(rd2_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forwarding copy differs only when a live write hits a nonzero read address.
  function automatic reg_data_t fwd(input reg_addr_t ra, input reg_data_t base);
    if (we3 && wa3 == ra && ra != 5'd0) return wd3;
    return base;
  endfunction

  task automatic chk(input string name, input reg_addr_t a1, input reg_addr_t a2,
                     input reg_data_t e1, input reg_data_t e2);
    exp_t it;
    ra1 = a1;
    ra2 = a2;
    #1;
    it.name = name;
    it.e1a  = e1;
    it.e2a  = e2;
    it.e1b  = fwd(a1, e1);
    it.e2b  = fwd(a2, e2);
    exp_q.push_back(it);
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s monitor timeout: pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wr(input reg_addr_t a, input reg_data_t d);
    we3 = 1'b1;
    wa3 = a;
    wd3 = d;
    @(posedge clk);
    #1;
    we3 = 1'b0;
  endtask

  // Monitor: combinational outputs are valid whenever an expectation is pending.
  initial begin
    exp_t it;
    forever begin
      wait (exp_q.size() != 0);
      it = exp_q[0];
      total += 4;
      if (rd1_a !== it.e1a) begin
        bad++;
        $display("FAIL %s rd1(bypass0) got=%h exp=%h", it.name, rd1_a, it.e1a);
      end
      if (rd2_a !== it.e2a) begin
        bad++;
        $display("FAIL %s rd2(bypass0) got=%h exp=%h", it.name, rd2_a, it.e2a);
      end
      if (rd1_b !== it.e1b) begin
        bad++;
        $display("FAIL %s rd1(bypass1) got=%h exp=%h", it.name, rd1_b, it.e1b);
      end
      if (rd2_b !== it.e2b) begin
        bad++;
        $display("FAIL %s rd2(bypass1) got=%h exp=%h", it.name, rd2_b, it.e2b);
      end
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    we3   = 1'b0;
    ra1   = '0;
    ra2   = '0;
    wa3   = '0;
    wd3   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 5'd5, 5'd31, 32'h0, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Async reset wipes a preloaded entry with no clock edge.
    wr(5'd5, 32'hDEAD_BEEF);
    chk("preload", 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    chk("reset_async", 5'd5, 5'd5, 32'h0, 32'h0);
    we3 = 1'b1; wa3 = 5'd6; wd3 = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_released", 5'd5, 5'd6, 32'h0, 32'h0);

    @(negedge clk);
    wr(5'd2, 32'd12);
    chk("basic_w2", 5'd2, 5'd3, 32'd12, 32'h0);
    wr(5'd3, 32'd7);
    chk("basic_w3", 5'd2, 5'd3, 32'd12, 32'd7);

    we3 = 1'b0; wa3 = 5'd4; wd3 = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("we_off", 5'd4, 5'd4, 32'h0, 32'h0);

    we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("reg0_write", 5'd0, 5'd0, 32'h0, 32'h0);
    we3 = 1'b0;

    wr(5'd9, 32'd1);
    we3 = 1'b1; wa3 = 5'd9; wd3 = 32'd2;
    chk("rdw_pre", 5'd9, 5'd2, 32'd1, 32'd12);
    @(posedge clk);
    #1;
    we3 = 1'b0;
    chk("rdw_post", 5'd9, 5'd9, 32'd2, 32'd2);

    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3));
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("sweep_%0d", i), 5'(i), 5'(31 - i),
          (i == 0) ? 32'h0 : 32'(i * 3),
          (i == 31) ? 32'h0 : 32'((31 - i) * 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
